control_game_flow: RTL

- Top-level game sequencing FSM that sits directly upstream of the datapath (data_game_flow).
- It drives the per-stage phase strobes (begin, draw_tower, in_progress, done) and the terminal win/game_over flags, and it consumes the datapath's *_done feedback.
- A single user "go" key advances the game between display screens, with rising-edge detection and a minimum on-screen dwell time per screen.

---
 rtl/control_game_flow.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/control_game_flow.sv
// Game sequencing FSM: steps through start screen, three stages
// (begin / tower / play / end) and the win / game-over screens, driving one
// registered phase strobe per state and consuming the datapath's done feedback.
module control_game_flow #(
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned DWELL_W      = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       start_display_done,
  input  logic       stage_1_begin_done,
  input  logic       stage_2_begin_done,
  input  logic       stage_3_begin_done,
  input  logic       stage_1_tower_done,
  input  logic       stage_2_tower_done,
  input  logic       stage_3_tower_done,
  input  logic       stage_1_car_done,
  input  logic       stage_2_car_done,
  input  logic       stage_3_car_done,
  input  logic       stage_1_end_display_done,
  input  logic       stage_2_end_display_done,
  input  logic       stage_3_end_display_done,
  input  logic       game_over_feedback,
  output logic       wait_start,
  output logic       stage_1_begin,
  output logic       stage_1_draw_tower,
  output logic       stage_1_in_progress,
  output logic       stage_1_done,
  output logic       stage_2_begin,
  output logic       stage_2_draw_tower,
  output logic       stage_2_in_progress,
  output logic       stage_2_done,
  output logic       stage_3_begin,
  output logic       stage_3_draw_tower,
  output logic       stage_3_in_progress,
  output logic       stage_3_done,
  output logic       win,
  output logic       game_over,
  output logic [1:0] current_stage,
  output logic [3:0] state_dbg
);

  localparam int unsigned NUM_STATES = 15;

  // Encoding order matches the phase-strobe bit order, so the strobes are a
  // plain one-hot decode of the state code.
  typedef enum logic [3:0] {
    WAIT_START = 4'd0,
    S1_BEGIN   = 4'd1,
    S1_TOWER   = 4'd2,
    S1_PLAY    = 4'd3,
    S1_END     = 4'd4,
    S2_BEGIN   = 4'd5,
    S2_TOWER   = 4'd6,
    S2_PLAY    = 4'd7,
    S2_END     = 4'd8,
    S3_BEGIN   = 4'd9,
    S3_TOWER   = 4'd10,
    S3_PLAY    = 4'd11,
    S3_END     = 4'd12,
    WIN        = 4'd13,
    OVER       = 4'd14
  } state_t;

  state_t                  state_q, state_d;
  logic [DWELL_W-1:0]      dwell_q, dwell_d;
  logic                    go_prev_q;
  logic                    done_seen_q, done_seen_d;
  logic [NUM_STATES-1:0]   phase_q, phase_d;
  logic [1:0]              stage_q, stage_d;

  logic                    go_press;
  logic                    dwell_ok;
  logic                    disp_state;
  logic                    disp_done_in;
  logic                    disp_adv;

  assign go_press = go & ~go_prev_q;
  assign dwell_ok = (dwell_q == DWELL_W'(DWELL_CYCLES));
  assign disp_adv = (disp_done_in | done_seen_q) & dwell_ok & go_press;

  // Identify display states and the done input that belongs to each.
  always_comb begin
    disp_state   = 1'b0;
    disp_done_in = 1'b0;
    case (state_q)
      WAIT_START: begin disp_state = 1'b1; disp_done_in = start_display_done;       end
      S1_END:     begin disp_state = 1'b1; disp_done_in = stage_1_end_display_done; end
      S2_END:     begin disp_state = 1'b1; disp_done_in = stage_2_end_display_done; end
      S3_END:     begin disp_state = 1'b1; disp_done_in = stage_3_end_display_done; end
      WIN, OVER:  begin disp_state = 1'b1; disp_done_in = 1'b1;                     end
      default:    ;
    endcase
  end

  // Next-state, dwell/done-latch and registered-output next values.
  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    done_seen_d = done_seen_q;
    phase_d     = phase_q;
    stage_d     = stage_q;

    case (state_q)
      WAIT_START: if (disp_adv) state_d = S1_BEGIN;
      S1_BEGIN:   if (stage_1_begin_done) state_d = S1_TOWER;
      S1_TOWER:   if (stage_1_tower_done) state_d = S1_PLAY;
      S1_PLAY:    if (game_over_feedback) state_d = OVER;
                  else if (stage_1_car_done) state_d = S1_END;
      S1_END:     if (disp_adv) state_d = S2_BEGIN;
      S2_BEGIN:   if (stage_2_begin_done) state_d = S2_TOWER;
      S2_TOWER:   if (stage_2_tower_done) state_d = S2_PLAY;
      S2_PLAY:    if (game_over_feedback) state_d = OVER;
                  else if (stage_2_car_done) state_d = S2_END;
      S2_END:     if (disp_adv) state_d = S3_BEGIN;
      S3_BEGIN:   if (stage_3_begin_done) state_d = S3_TOWER;
      S3_TOWER:   if (stage_3_tower_done) state_d = S3_PLAY;
      S3_PLAY:    if (game_over_feedback) state_d = OVER;
                  else if (stage_3_car_done) state_d = S3_END;
      S3_END:     if (disp_adv) state_d = WIN;
      WIN, OVER:  if (disp_adv) state_d = WAIT_START;
      default:    state_d = WAIT_START;
    endcase

    if (state_d != state_q) begin
      dwell_d     = '0;
      done_seen_d = 1'b0;
    end else begin
      if (disp_state && !dwell_ok) dwell_d = dwell_q + DWELL_W'(1);
      if (disp_state && disp_done_in) done_seen_d = 1'b1;
    end

    phase_d = NUM_STATES'(1) << state_d;

    case (state_d)
      S1_BEGIN, S1_TOWER, S1_PLAY, S1_END: stage_d = 2'd1;
      S2_BEGIN, S2_TOWER, S2_PLAY, S2_END: stage_d = 2'd2;
      S3_BEGIN, S3_TOWER, S3_PLAY, S3_END: stage_d = 2'd3;
      default:                             stage_d = 2'd0;
    endcase
  end

  // State, dwell counter, key history and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_START;
      dwell_q     <= '0;
      go_prev_q   <= 1'b1;
      done_seen_q <= 1'b0;
      phase_q     <= NUM_STATES'(1);
      stage_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      go_prev_q   <= go;
      done_seen_q <= done_seen_d;
      phase_q     <= phase_d;
      stage_q     <= stage_d;
    end
  end

  assign wait_start          = phase_q[0];
  assign stage_1_begin       = phase_q[1];
  assign stage_1_draw_tower  = phase_q[2];
  assign stage_1_in_progress = phase_q[3];
  assign stage_1_done        = phase_q[4];
  assign stage_2_begin       = phase_q[5];
  assign stage_2_draw_tower  = phase_q[6];
  assign stage_2_in_progress = phase_q[7];
  assign stage_2_done        = phase_q[8];
  assign stage_3_begin       = phase_q[9];
  assign stage_3_draw_tower  = phase_q[10];
  assign stage_3_in_progress = phase_q[11];
  assign stage_3_done        = phase_q[12];
  assign win                 = phase_q[13];
  assign game_over           = phase_q[14];
  assign current_stage       = stage_q;
  assign state_dbg           = state_q;

endmodule
